// File: rtl/mmio_bridge.sv
// mmio_bridge: data-side bridge from the processor dmem port to the data RAM
// and the peripheral bus. It has three address windows:
//   RAM   : address_dmem < 2**RAM_AW. Passed straight through; the read data
//           comes from the synchronous RAM one cycle later.
//   POST  : 0x0000F000-0x0000F0FF. Writes are queued in a posted-write FIFO
//           and drained over a valid/ready bus. Reads return 0.
//   LOCAL : 0x0000F100-0x0000F1FF. Local registers: STATUS, SENSOR and CYCLE.
// Every read completes in one cycle, the same as the RAM, so the pipeline
// never needs to stall.
// Optional feature: define MMIO_CYCLE_COUNTER_EN to build the free-running
// CYCLE counter at 0xF102. Without it, no counter logic is built and 0xF102
// reads 0.
module mmio_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int RAM_AW     = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       address_dmem,
    input  logic [31:0]       data,
    input  logic              wren,
    output logic [31:0]       q_dmem,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    input  logic [31:0]       ram_q,
    output logic              periph_valid,
    input  logic              periph_ready,
    output logic [7:0]        periph_addr,
    output logic [31:0]       periph_wdata,
    input  logic [15:0]       sensor_in
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = PW + 1;

    localparam logic [7:0] OFS_STATUS = 8'h00;
    localparam logic [7:0] OFS_SENSOR = 8'h01;
    localparam logic [7:0] OFS_CYCLE  = 8'h02;

    // Address decode. RAM has priority over the other windows.
    logic is_ram;
    logic is_post;
    logic is_local;

    // FIFO state and control
    logic [39:0]   mem_q [FIFO_DEPTH];
    logic [39:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          post_wr;
    logic          push;
    logic          pop;

    // Sticky overflow flag and sensor synchronizer
    logic          ovf_q, ovf_d;
    logic [15:0]   sync1_q, sync1_d;
    logic [15:0]   sync2_q, sync2_d;

    // Read return path
    logic [31:0]   rdata_q, rdata_d;
    logic          ram_sel_q, ram_sel_d;
    logic [4:0]    level5;
    logic [31:0]   status_word;
    logic [31:0]   cycle_val;

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0]   cycle_q, cycle_d;
`endif

    // Window decode of the processor address
    always_comb begin
        is_ram   = ((address_dmem >> RAM_AW) == 32'd0);
        is_post  = !is_ram && (address_dmem[31:8] == 24'h0000F0);
        is_local = !is_ram && (address_dmem[31:8] == 24'h0000F1);
    end

    assign ram_addr = address_dmem[RAM_AW-1:0];
    assign ram_data = data;
    assign ram_wren = wren && is_ram;

    // FIFO flags. A push is refused when the FIFO is full at the start of the
    // cycle, even if a pop happens in the same cycle.
    always_comb begin
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LW'(FIFO_DEPTH));
        post_wr    = is_post && wren;
        push       = post_wr && !fifo_full;
        pop        = !fifo_empty && periph_ready;
    end

    assign periph_valid = !fifo_empty;
    assign periph_addr  = mem_q[rd_ptr_q][39:32];
    assign periph_wdata = mem_q[rd_ptr_q][31:0];

    // Next FIFO pointers, level and storage
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = {address_dmem[7:0], data};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Overflow flag. A write to STATUS with data[0]=1 clears it, but an
    // overflow in the same cycle takes priority.
    always_comb begin
        ovf_d = ovf_q;
        if (is_local && wren && (address_dmem[7:0] == OFS_STATUS) && data[0]) begin
            ovf_d = 1'b0;
        end
        if (post_wr && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous sensor levels
    always_comb begin
        sync1_d = sensor_in;
        sync2_d = sync1_q;
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    // Free-running cycle counter. It wraps to 0 after 0xFFFFFFFF.
    always_comb begin
        cycle_d   = cycle_q + 32'd1;
        cycle_val = cycle_q;
    end
`else
    assign cycle_val = 32'd0;
`endif

    // Local register read mux. The value is captured at the edge so that the
    // read takes one cycle, like a RAM read.
    always_comb begin
        level5      = 5'(level_q);
        status_word = {ovf_q, 24'd0, fifo_full, fifo_empty, level5};
        rdata_d     = 32'd0;
        ram_sel_d   = is_ram;
        if (is_local) begin
            case (address_dmem[7:0])
                OFS_STATUS: rdata_d = status_word;
                OFS_SENSOR: rdata_d = {16'd0, sync2_q};
                OFS_CYCLE:  rdata_d = cycle_val;
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    assign q_dmem = ram_sel_q ? ram_q : rdata_q;

    // Control and status registers, with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            rdata_q   <= '0;
            ram_sel_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            rdata_q   <= rdata_d;
            ram_sel_q <= ram_sel_d;
        end
    end

    // FIFO storage. It has no reset; an entry is only seen through periph_valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    // Cycle counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end
`endif

endmodule
